// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with step, branch, jump,
// call/return through a circular return-address stack, and stall.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hold pc, RAS and flags; requests are dropped
//   branch_en/offset  pc <- pc + offset (two's complement, wraps)
//   jump_en/target    pc <- target; with call_en, push pc + STEP
//   ret_en            pop RAS into pc (pc + STEP and underflow if empty)
//   pc, pc_plus_step  fetch address and its combinational successor
//   ras_empty/full    decoded from the entry count
//   ras_overflow      sticky: push while full
//   ras_underflow     sticky: pop while empty
module pc_sequencer #(
    parameter int                     WIDTH        = 16,
    parameter int                     STEP         = 1,
    parameter logic [WIDTH-1:0]       RESET_VECTOR = '0,
    parameter int                     RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);

    logic [WIDTH-1:0] rasMem [RAS_DEPTH];
    logic [PTR_W-1:0] topPtr;
    logic [CNT_W-1:0] rasCount;
    logic [PTR_W-1:0] pushPtr;

    assign pc_plus_step = pc + STEP_W;
    assign ras_empty    = (rasCount == '0);
    assign ras_full     = (rasCount == CNT_FULL);

    // The slot above top is free when not full and holds the oldest
    // entry when full, so a push always writes there and advances top.
    assign pushPtr = topPtr + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_VECTOR;
            topPtr        <= PTR_LAST;
            rasCount      <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (!stall) begin
            if (ret_en) begin
                if (ras_empty) begin
                    pc            <= pc_plus_step;
                    ras_underflow <= 1'b1;
                end else begin
                    pc       <= rasMem[topPtr];
                    topPtr   <= topPtr - 1'b1;
                    rasCount <= rasCount - 1'b1;
                end
            end else if (jump_en) begin
                pc <= jump_target;
                if (call_en) begin
                    rasMem[pushPtr] <= pc_plus_step;
                    topPtr          <= pushPtr;
                    if (ras_full) begin
                        ras_overflow <= 1'b1;
                    end else begin
                        rasCount <= rasCount + 1'b1;
                    end
                end
            end else if (branch_en) begin
                pc <= pc + branch_offset;
            end else begin
                pc <= pc_plus_step;
            end
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the fixed 16-bit PC incrementer.
- Owns the registered program counter: sequential step, relative branch, absolute jump, call/return through an internal return-address stack (RAS), and stall.
- Sits between the control unit and instruction memory; drives the fetch address every cycle.

Parameters:
- WIDTH, 16, PC and address width in bits.
- STEP, 1, sequential increment in address units; must be ≥1 and < 2^WIDTH.
- RESET_VECTOR, 0, PC value loaded on reset; WIDTH bits.
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold all state this cycle
- branch_en  input  1  take relative branch
- branch_offset  input  WIDTH  two's-complement offset added to current pc
- jump_en  input  1  take absolute jump
- jump_target  input  WIDTH  absolute jump destination
- call_en  input  1  with jump_en: push return address
- ret_en  input  1  pop RAS into pc
- pc  output  WIDTH  registered program counter (fetch address)
- pc_plus_step  output  WIDTH  combinational pc + STEP, mod 2^WIDTH
- ras_empty  output  1  RAS holds 0 entries
- ras_full  output  1  RAS holds RAS_DEPTH entries
- ras_overflow  output  1  sticky: push occurred while full
- ras_underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (clk edge with reset=1) overrides every other input. Values after reset:
  - pc = RESET_VECTOR
  - RAS count = 0, so ras_empty=1 and ras_full=0
  - ras_overflow = 0, ras_underflow = 0
  - RAS entry contents are don't-care
- Reset asserted mid-sequence (including during a stall) discards pending requests and clears RAS and flags the same way.
- All arithmetic is unsigned modulo 2^WIDTH. Overflow past all-ones wraps silently, e.g. WIDTH=16: 0xFFFF + 1 = 0x0000. Branch offset is sign-interpreted by wrap.
- Latency: a request sampled at edge N is visible on pc after edge N. pc_plus_step follows pc combinationally.
- stall=1: pc, RAS contents and count, and both flags hold. All request inputs are ignored, not queued.
- Next-pc priority when stall=0 (highest first):
  1. ret_en:
     - RAS non-empty: pc ← top entry; count −1.
     - RAS empty: pc ← pc+STEP; ras_underflow ← 1; count unchanged.
  2. jump_en: pc ← jump_target. If call_en=1 also, push pc+STEP.
  3. branch_en: pc ← pc + branch_offset (base is current pc, not pc+STEP).
  4. Otherwise: pc ← pc+STEP.
- Lower-priority requests asserted together with a higher one are dropped. A call accompanying a taken ret does not push.
- call_en without jump_en has no effect.
- RAS is circular, with top pointer and count.
  - Push when not full: write at top+1, count +1.
  - Push when full: overwrite the oldest entry; count stays RAS_DEPTH; ras_overflow ← 1. The newest RAS_DEPTH return addresses are retained.
- ras_overflow and ras_underflow are sticky until reset.
- Implementation form:
  - Single always block for pc, pointer, count and flags; RAS as a register array.
  - ras_empty/ras_full decoded from count.
  - Count width is clog2(RAS_DEPTH)+1.

Test Plan:
- Reset then free-run, WIDTH=16, STEP=1, RESET_VECTOR=0x0100 → pc: 0x0100, 0x0101, 0x0102; pc_plus_step = pc+1 each cycle.
- Wrap: jump_target=0xFFFE, then 3 free cycles → pc 0xFFFE, 0xFFFF, 0x0000, 0x0001. Backward branch at pc=0x0010 with offset 0xFFF0 → pc 0x0000.
- Call/return: at pc=0x0020, jump_en+call_en to 0x0200; free 2 cycles; ret_en → pc 0x0200, 0x0201, 0x0202, then 0x0021; ras_empty returns to 1.
- Overflow: 5 calls with RAS_DEPTH=4 from pcs A..E → ras_full=1, ras_overflow=1. Four rets return E+1, D+1, C+1, B+1. Fifth ret → pc+1 and ras_underflow=1.
- Priority and stall:
  - ret_en+jump_en+branch_en with RAS top 0x0300 → pc 0x0300, no push.
  - stall=1 for 3 cycles with jump_en asserted → pc and count unchanged; jump not taken after stall drops.
- Reset mid-operation: 2 entries on RAS, overflow flag set, assert reset during stall → next cycle pc=RESET_VECTOR, ras_empty=1, both flags 0.
